// File: rtl/exe_divider.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EXE stage.
// Stalls the ID->EXE handoff while busy and holds quotient/remainder until acknowledged.
module exe_divider (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_op,
  input  logic        divu_op,
  input  logic [31:0] src_x,
  input  logic [31:0] src_y,
  input  logic        cancel,
  input  logic        result_ack,
  output logic        is_div_block,
  output logic        is_divu_block,
  output logic [31:0] div_quot,
  output logic [31:0] div_rem,
  output logic        div_done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic        sgn_op, sign_x, sign_y, zero_div;
  logic [31:0] dvd, dvs, raw_x;
  logic [32:0] rem;

  logic        start;
  logic [32:0] rem_sh, rem_sub, rem_nx;
  logic        q_bit;
  logic [31:0] dvd_nx, quot_fix, rem_fix;

  assign start = (div_op | divu_op) & !cancel;

  // One restoring step: the dividend register doubles as the quotient shift register.
  always_comb begin
    rem_sh  = {rem[31:0], dvd[31]};
    rem_sub = rem_sh - {1'b0, dvs};
    q_bit   = (rem_sh >= {1'b0, dvs});
    rem_nx  = q_bit ? rem_sub : rem_sh;
    dvd_nx  = {dvd[30:0], q_bit};
  end

  always_comb begin
    quot_fix = dvd_nx;
    rem_fix  = rem_nx[31:0];
    if (zero_div) begin
      quot_fix = '1;
      rem_fix  = raw_x;
    end else if (sgn_op) begin
      if (sign_x ^ sign_y) quot_fix = -dvd_nx;
      if (sign_x)          rem_fix  = -rem_nx[31:0];
    end
  end

  always_comb begin
    state_nx = state;
    if (cancel) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (div_op | divu_op) state_nx = BUSY;
        BUSY:    if (cnt == 5'd31)     state_nx = DONE;
        DONE:    if (result_ack)       state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      sgn_op   <= 1'b0;
      sign_x   <= 1'b0;
      sign_y   <= 1'b0;
      zero_div <= 1'b0;
      dvd      <= '0;
      dvs      <= '0;
      raw_x    <= '0;
      rem      <= '0;
      div_quot <= '0;
      div_rem  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sgn_op   <= div_op;
            sign_x   <= src_x[31];
            sign_y   <= src_y[31];
            zero_div <= (src_y == '0);
            dvd      <= (div_op & src_x[31]) ? -src_x : src_x;
            dvs      <= (div_op & src_y[31]) ? -src_y : src_y;
            raw_x    <= src_x;
            rem      <= '0;
            cnt      <= '0;
          end
        end
        BUSY: begin
          if (!cancel) begin
            rem <= rem_nx;
            dvd <= dvd_nx;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              div_quot <= quot_fix;
              div_rem  <= rem_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign is_div_block  = div_op  & !cancel & (state != DONE);
  assign is_divu_block = divu_op & !cancel & (state != DONE);
  assign div_done      = (state == DONE);

endmodule

// File: tb/tb_exe_divider.sv
// Scoreboard bench for exe_divider: latency, sign fix-up, divide-by-zero, hold, cancel, reset.
module tb_exe_divider;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_op, divu_op, cancel, result_ack;
  logic [31:0] src_x, src_y;
  logic        is_div_block, is_divu_block, div_done;
  logic [31:0] div_quot, div_rem;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;
  logic [63:0] sb_q[$];
  logic [31:0] last_q, last_r;

  exe_divider dut (
    .clk           (clk),
    .resetn        (resetn),
    .div_op        (div_op),
    .divu_op       (divu_op),
    .src_x         (src_x),
    .src_y         (src_y),
    .cancel        (cancel),
    .result_ack    (result_ack),
    .is_div_block  (is_div_block),
    .is_divu_block (is_divu_block),
    .div_quot      (div_quot),
    .div_rem       (div_rem),
    .div_done      (div_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q, r;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (!sgn) begin
      q = x / y;
      r = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'($signed(x) / $signed(y));
      r = 32'($signed(x) % $signed(y));
    end
    return {q, r};
  endfunction

  // Starts in the current cycle (cycle 0), runs to DONE, holds for `hold` cycles, then acks.
  task automatic run_div(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                         input int unsigned hold, input string name);
    logic [63:0] exp;
    int unsigned nblk, cyc;
    sb_q.push_back(model(sgn, x, y));
    div_op = sgn; divu_op = !sgn; src_x = x; src_y = y;
    cancel = 1'b0; result_ack = 1'b0;
    nblk = 0; cyc = 0;
    #1;
    while (!div_done && cyc < 100) begin
      if (is_div_block | is_divu_block) nblk++;
      @(posedge clk); #1;
      src_x = $urandom; src_y = $urandom;
      #1;
      cyc++;
    end
    n_run++;
    if (cyc !== 33 || nblk !== 33) begin
      n_fail++;
      $display("FAIL %s latency: done at cycle %0d with %0d block cycles, required 33/33", name, cyc, nblk);
    end
    n_run++;
    if ((is_div_block | is_divu_block) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s block_in_done: got %b, required 0", name, is_div_block | is_divu_block);
    end
    exp = sb_q.pop_front();
    last_q = exp[63:32];
    last_r = exp[31:0];
    n_run++;
    if (div_quot !== exp[63:32]) begin
      n_fail++;
      $display("FAIL %s quot: got %h, required %h", name, div_quot, exp[63:32]);
    end
    n_run++;
    if (div_rem !== exp[31:0]) begin
      n_fail++;
      $display("FAIL %s rem: got %h, required %h", name, div_rem, exp[31:0]);
    end
    for (int i = 0; i < int'(hold); i++) begin
      @(posedge clk); #2;
      n_run++;
      if (div_done !== 1'b1 || div_quot !== exp[63:32] || div_rem !== exp[31:0]) begin
        n_fail++;
        $display("FAIL %s hold%0d: done=%b quot=%h rem=%h, required 1 %h %h",
                 name, i, div_done, div_quot, div_rem, exp[63:32], exp[31:0]);
      end
    end
    result_ack = 1'b1;
    @(posedge clk); #1;
    div_op = 1'b0; divu_op = 1'b0; result_ack = 1'b0;
    #1;
    n_run++;
    if (div_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after_ack: done=%b, required 0", name, div_done);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; div_op = 1'b0; divu_op = 1'b0; cancel = 1'b0; result_ack = 1'b0;
    src_x = '0; src_y = '0;
    repeat (2) @(posedge clk);
    #2;
    n_run++;
    if (div_quot !== 32'd0 || div_rem !== 32'd0 || div_done !== 1'b0 ||
        is_div_block !== 1'b0 || is_divu_block !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: quot=%h rem=%h done=%b blk=%b%b, required all 0",
               div_quot, div_rem, div_done, is_div_block, is_divu_block);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    run_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
  endtask

  task automatic test_signed();
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
  endtask

  task automatic test_div_zero();
    run_div(1'b0, 32'hFFFF_FFFF, 32'd0, 0, "divu_by_zero");
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 0, "div_m5_by_zero");
  endtask

  task automatic test_back_to_back();
    run_div(1'b1, 32'd1000, 32'd10, 5, "div_hold");
    run_div(1'b0, 32'd9, 32'd4, 0, "divu_b2b");
  endtask

  task automatic test_cancel();
    div_op = 1'b1; divu_op = 1'b0; src_x = 32'd123456; src_y = 32'd11;
    repeat (10) begin
      @(posedge clk); #1;
    end
    cancel = 1'b1;
    #1;
    n_run++;
    if (is_div_block !== 1'b0 || div_done !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_block: blk=%b done=%b, required 0 0", is_div_block, div_done);
    end
    @(posedge clk); #1;
    cancel = 1'b0;
    n_run++;
    if (div_done !== 1'b0 || div_quot !== last_q || div_rem !== last_r) begin
      n_fail++;
      $display("FAIL cancel_keep: done=%b quot=%h rem=%h, required 0 %h %h",
               div_done, div_quot, div_rem, last_q, last_r);
    end
    run_div(1'b1, 32'hFFFE_1DC0, 32'd77, 0, "div_after_cancel");
  endtask

  task automatic test_reset_mid();
    div_op = 1'b1; divu_op = 1'b0; src_x = 32'd50000; src_y = 32'd3;
    repeat (15) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0; div_op = 1'b0;
    #1;
    n_run++;
    if (div_quot !== 32'd0 || div_rem !== 32'd0 || div_done !== 1'b0 ||
        is_div_block !== 1'b0 || is_divu_block !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: quot=%h rem=%h done=%b, required 0 0 0", div_quot, div_rem, div_done);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    run_div(1'b1, 32'd9, 32'd3, 0, "div_after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
